// File: rtl/thinning_scheduler.sv
// Zhang-Suen thinning scheduler: ping-pong frame scan, 3x3 window fetch,
// delete/keep decision from external popcount and internal transition count.
module thinning_scheduler #(
  parameter int WIDTH    = 64,
  parameter int HEIGHT   = 48,
  parameter int ADDR_W   = 13,
  parameter int MAX_ITER = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           result_bank,
  output logic [$clog2(MAX_ITER+1)-1:0]  iter_count,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_rd,
  input  logic                           mem_rdata,
  output logic                           mem_wr,
  output logic                           mem_wdata,
  output logic [7:0]                     nbr,
  input  logic [3:0]                     nbr_count
);
  localparam int IW   = $clog2(MAX_ITER+1);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int NPIX = WIDTH * HEIGHT;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_C, S_CAP_C, S_FETCH,
    S_LAST, S_EVAL, S_WR, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              src_q, src_d;
  logic              sub_q, sub_d;
  logic              changed_q, changed_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic [2:0]        slot_q, slot_d;
  logic [7:0]        nb_q, nb_d;
  logic              rdp_q, rdp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rbank_q, rbank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              wdata_q, wdata_d;
  logic [7:0]        nbr_q, nbr_d;

  int            sl, nx, ny;
  logic          inf;
  logic [3:0]    a_cnt;
  logic          del;
  logic [IW-1:0] iter_n;

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic bank, input int px, input int py);
    return ADDR_W'(int'(bank) * NPIX + py * WIDTH + px);
  endfunction

  function automatic int dx_of(input int k);
    case (k)
      1, 2, 3: return 1;
      5, 6, 7: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dy_of(input int k);
    case (k)
      0, 1, 7: return -1;
      3, 4, 5: return 1;
      default: return 0;
    endcase
  endfunction

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_bank = rbank_q;
  assign iter_count  = iter_q;
  assign mem_addr    = addr_q;
  assign mem_rd      = rd_q;
  assign mem_wr      = wr_q;
  assign mem_wdata   = wdata_q;
  assign nbr         = nbr_q;

  // Next neighbour slot to issue, and the keep/delete decision.
  always_comb begin
    sl  = (state_q == S_FETCH) ? int'(slot_q) + 1 : 0;
    nx  = int'(x_q) + dx_of(sl);
    ny  = int'(y_q) + dy_of(sl);
    inf = (nx >= 0) && (nx < WIDTH) && (ny >= 0) && (ny < HEIGHT);
    a_cnt = '0;
    for (int i = 0; i < 8; i++)
      a_cnt = a_cnt + 4'(!nb_q[i] && nb_q[(i+1)%8]);
    del = (nbr_count >= 4'd2) && (nbr_count <= 4'd6) &&
          (a_cnt == 4'd1) &&
          (sub_q ? (!(nb_q[0] & nb_q[2] & nb_q[6]) &&
                    !(nb_q[0] & nb_q[4] & nb_q[6]))
                 : (!(nb_q[0] & nb_q[2] & nb_q[4]) &&
                    !(nb_q[2] & nb_q[4] & nb_q[6])));
    iter_n = (iter_q == IW'(MAX_ITER)) ? iter_q : iter_q + IW'(1);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    src_d     = src_q;
    sub_d     = sub_q;
    changed_d = changed_q;
    iter_d    = iter_q;
    slot_d    = slot_q;
    nb_d      = nb_q;
    rdp_d     = rd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rbank_d   = rbank_q;
    addr_d    = addr_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    wdata_d   = 1'b0;
    nbr_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          iter_d    = '0;
          changed_d = 1'b0;
          sub_d     = 1'b0;
          src_d     = 1'b0;
          x_d       = '0;
          y_d       = '0;
          rd_d      = 1'b1;
          addr_d    = addr_of(1'b0, 0, 0);
          state_d   = S_RD_C;
        end
      end
      S_RD_C: state_d = S_CAP_C;
      S_CAP_C: begin
        if (mem_rdata) begin
          nb_d    = '0;
          slot_d  = '0;
          rd_d    = inf;
          if (inf) addr_d = addr_of(src_q, nx, ny);
          state_d = S_FETCH;
        end else begin
          wr_d    = 1'b1;
          addr_d  = addr_of(!src_q, int'(x_q), int'(y_q));
          state_d = S_WR;
        end
      end
      S_FETCH: begin
        if (slot_q != 3'd0)
          nb_d[slot_q - 3'd1] = rdp_q & mem_rdata;
        if (slot_q == 3'd7) begin
          state_d = S_LAST;
        end else begin
          slot_d = slot_q + 3'd1;
          rd_d   = inf;
          if (inf) addr_d = addr_of(src_q, nx, ny);
        end
      end
      S_LAST: begin
        nb_d[7] = rdp_q & mem_rdata;
        nbr_d   = nb_d;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        wr_d    = 1'b1;
        wdata_d = !del;
        addr_d  = addr_of(!src_q, int'(x_q), int'(y_q));
        if (del) changed_d = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        if (int'(x_q) != WIDTH - 1) begin
          x_d     = x_q + XW'(1);
          rd_d    = 1'b1;
          addr_d  = addr_of(src_q, int'(x_q) + 1, int'(y_q));
          state_d = S_RD_C;
        end else if (int'(y_q) != HEIGHT - 1) begin
          x_d     = '0;
          y_d     = y_q + YW'(1);
          rd_d    = 1'b1;
          addr_d  = addr_of(src_q, 0, int'(y_q) + 1);
          state_d = S_RD_C;
        end else begin
          x_d   = '0;
          y_d   = '0;
          src_d = !src_q;
          if (!sub_q) begin
            sub_d   = 1'b1;
            rd_d    = 1'b1;
            addr_d  = addr_of(!src_q, 0, 0);
            state_d = S_RD_C;
          end else begin
            iter_d = iter_n;
            if (!changed_q || iter_n == IW'(MAX_ITER)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              rbank_d = !src_q;
              state_d = S_DONE;
            end else begin
              changed_d = 1'b0;
              sub_d     = 1'b0;
              rd_d      = 1'b1;
              addr_d    = addr_of(!src_q, 0, 0);
              state_d   = S_RD_C;
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      src_q     <= 1'b0;
      sub_q     <= 1'b0;
      changed_q <= 1'b0;
      iter_q    <= '0;
      slot_q    <= '0;
      nb_q      <= '0;
      rdp_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rbank_q   <= 1'b0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= 1'b0;
      nbr_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      src_q     <= src_d;
      sub_q     <= sub_d;
      changed_q <= changed_d;
      iter_q    <= iter_d;
      slot_q    <= slot_d;
      nb_q      <= nb_d;
      rdp_q     <= rdp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rbank_q   <= rbank_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      nbr_q     <= nbr_d;
    end
  end
endmodule

// File: tb/tb_thinning_scheduler.sv
// Bench for thinning_scheduler: 4x4 frames, two instances (MAX_ITER 16 / 1),
// behavioural RAM and popcounter, scoreboard of expected final results.
module tb_thinning_scheduler;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 6;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] busy, done, rbank, rd, wr, wdata;
  logic [1:0] rdata = '0;
  logic [4:0] iter0;
  logic [0:0] iter1;
  logic [AW-1:0] addr [2];
  logic [7:0] nbr [2];
  logic [3:0] cnt [2];

  logic mem [2][2*N];
  logic [1:0] ld = '0;
  logic [N-1:0] ld_img = '0;

  int n_checks = 0;
  int n_errors = 0;
  int both_cnt = 0;
  int rd_cnt [2] = '{0, 0};
  int wr_cnt [2] = '{0, 0};
  int last_reads = 0;

  typedef struct {
    string tag;
    int which;
    int iter;
    logic [N-1:0] img;
    int cyc;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  assign cnt[0] = 4'($countones(nbr[0]));
  assign cnt[1] = 4'($countones(nbr[1]));

  thinning_scheduler #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW),
                       .MAX_ITER(16)) u0 (
    .clk(clk), .reset(reset), .start(start[0]),
    .busy(busy[0]), .done(done[0]), .result_bank(rbank[0]),
    .iter_count(iter0), .mem_addr(addr[0]), .mem_rd(rd[0]),
    .mem_rdata(rdata[0]), .mem_wr(wr[0]), .mem_wdata(wdata[0]),
    .nbr(nbr[0]), .nbr_count(cnt[0]));

  thinning_scheduler #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW),
                       .MAX_ITER(1)) u1 (
    .clk(clk), .reset(reset), .start(start[1]),
    .busy(busy[1]), .done(done[1]), .result_bank(rbank[1]),
    .iter_count(iter1), .mem_addr(addr[1]), .mem_rd(rd[1]),
    .mem_rdata(rdata[1]), .mem_wr(wr[1]), .mem_wdata(wdata[1]),
    .nbr(nbr[1]), .nbr_count(cnt[1]));

  // Bank 1 preloaded with ones so unwritten pixels show up.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ld[i]) begin
        for (int a = 0; a < N; a++) begin
          mem[i][a]   <= ld_img[a];
          mem[i][N+a] <= 1'b1;
        end
      end else if (wr[i]) begin
        mem[i][addr[i]] <= wdata[i];
      end
      if (rd[i]) rdata[i] <= mem[i][addr[i]];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd[i] && wr[i]) both_cnt++;
      if (rd[i]) rd_cnt[i]++;
      if (wr[i]) wr_cnt[i]++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] bank_img(input int i, input int b);
    logic [N-1:0] v;
    for (int a = 0; a < N; a++) v[a] = mem[i][b*N + a];
    return v;
  endfunction

  task automatic run_case(input int which, input string tag,
                          input logic [N-1:0] img,
                          input logic [N-1:0] exp_img, input int it,
                          input int cyc, input bit extra_start);
    exp_t e;
    int n;
    int r0;
    int got_iter;
    ld_img = img;
    @(negedge clk) ld[which] = 1'b1;
    @(negedge clk) ld[which] = 1'b0;
    e.tag = tag; e.which = which; e.iter = it;
    e.img = exp_img; e.cyc = cyc;
    sb.push_back(e);
    r0 = rd_cnt[which];
    start[which] = 1'b1;
    @(negedge clk) start[which] = 1'b0;
    n = 0;
    while (!done[which] && n < 3000) begin
      @(negedge clk);
      n++;
      start[which] = extra_start && (n == 5);
    end
    start[which] = 1'b0;
    check({tag, "_done_seen"}, int'(done[which]), 1);
    e = sb.pop_front();
    got_iter = (e.which == 1) ? int'(iter1) : int'(iter0);
    check({e.tag, "_iter"}, got_iter, e.iter);
    check({e.tag, "_bank"}, int'(rbank[e.which]), 0);
    check({e.tag, "_img0"}, int'(bank_img(e.which, 0)), int'(e.img));
    check({e.tag, "_img1"}, int'(bank_img(e.which, 1)), int'(e.img));
    if (e.cyc >= 0) check({e.tag, "_cycles"}, n, e.cyc);
    last_reads = rd_cnt[which] - r0;
    @(negedge clk);
    check({e.tag, "_done_pulse"}, int'(done[which]), 0);
    check({e.tag, "_busy_off"}, int'(busy[which]), 0);
  endtask

  initial begin
    int r0;
    int w0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd", int'(rd), 0);
    check("rst_wr", int'(wr), 0);
    check("rst_nbr", int'({nbr[0], nbr[1]}), 0);
    check("rst_iter", int'({iter0, iter1}), 0);
    reset = 1'b0;
    @(negedge clk);

    run_case(0, "zero", '0, '0, 1, 96, 1'b0);
    run_case(0, "block", 16'h0660, '0, 2, -1, 1'b0);
    run_case(1, "maxit1", 16'h0660, '0, 1, -1, 1'b0);
    run_case(0, "single", 16'h0001, 16'h0001, 1, -1, 1'b0);
    check("single_reads", last_reads, 38);

    ld_img = 16'h0660;
    @(negedge clk) ld[0] = 1'b1;
    @(negedge clk) ld[0] = 1'b0;
    start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_busy", int'(busy[0]), 1);
    reset = 1'b1;
    @(negedge clk);
    r0 = rd_cnt[0];
    w0 = wr_cnt[0];
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_rd", rd_cnt[0] - r0, 0);
    check("abort_wr", wr_cnt[0] - w0, 0);
    check("abort_busy", int'(busy[0]), 0);
    run_case(0, "restart", 16'h0660, '0, 2, -1, 1'b1);

    check("rd_wr_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
